ftsd_scan_ctl_pwm: RTL and testbench

Parametrised, self-timed scan controller for a multiplexed N-digit 14-segment display. It has an internal refresh timer and a frame-coherent shadow register for the digit codes. Each digit slot starts with an anti-ghosting blanking interval, and lit time is PWM-controlled for brightness. It sits between the display-content logic and the 14-segment decoder, replacing externally divided scan-select clocks.

---
 rtl/ftsd_scan_ctl_pwm.sv | 107 ++++++++++
 tb/tb_ftsd_scan_ctl_pwm.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ftsd_scan_ctl_pwm.sv
// Self-timed scan controller for a multiplexed 14-segment display: internal refresh timer,
// frame-coherent code shadow, anti-ghosting blanking and PWM brightness per digit slot.
module ftsd_scan_ctl_pwm #(
    parameter int NUM_DIGIT = 4,
    parameter int DATA_W    = 6,
    parameter int DWELL     = 1024,
    parameter int BLANK     = 64,
    parameter int CNT_W     = $clog2(DWELL + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          scan_en,
    input  logic [NUM_DIGIT*DATA_W-1:0]   in_bus,
    input  logic [NUM_DIGIT-1:0]          digit_en,
    input  logic [CNT_W-1:0]              brightness,
    output logic [NUM_DIGIT-1:0]          ftsd_ctl,
    output logic [DATA_W-1:0]             ftsd_in,
    output logic [$clog2(NUM_DIGIT)-1:0]  digit_idx,
    output logic                          frame_start
);

    localparam int IDX_W = $clog2(NUM_DIGIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] BLANK_C = CNT_W'(BLANK);
    localparam logic [CNT_W-1:0] LIT_MAX = CNT_W'(DWELL - BLANK);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGIT - 1);

    logic                        run_q, run_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [NUM_DIGIT*DATA_W-1:0] shadow_q, shadow_d;
    logic [NUM_DIGIT-1:0]        ctl_d;
    logic [DATA_W-1:0]           in_d;
    logic                        fs_d;
    logic [CNT_W-1:0]            bright_sat;
    logic                        lit;

    // run_q separates the parked (0,0) state from the first scanning cycle at (0,0).
    always_comb begin
        run_d    = run_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        if (!scan_en) begin
            run_d    = 1'b0;
            cnt_d    = '0;
            idx_d    = '0;
            shadow_d = in_bus;
        end else if (!run_q) begin
            run_d    = 1'b1;
            cnt_d    = '0;
            idx_d    = '0;
            shadow_d = in_bus;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            if (idx_q == IDX_MAX) begin
                idx_d    = '0;
                shadow_d = in_bus;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Outputs are decoded from next-state so they line up with the registered (idx, cnt).
    always_comb begin
        bright_sat = (brightness > LIT_MAX) ? LIT_MAX : brightness;
        lit = run_d && (cnt_d >= BLANK_C) && ((cnt_d - BLANK_C) < bright_sat) &&
              digit_en[idx_d];
        ctl_d = '1;
        in_d  = '0;
        for (int i = 0; i < NUM_DIGIT; i++) begin
            if (lit && (idx_d == IDX_W'(NUM_DIGIT - 1 - i))) begin
                ctl_d[i] = 1'b0;
            end
            if (run_d && (idx_d == IDX_W'(i))) begin
                in_d = shadow_d[i*DATA_W +: DATA_W];
            end
        end
        fs_d = run_d && (cnt_d == '0) && (idx_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q       <= 1'b0;
            cnt_q       <= '0;
            idx_q       <= '0;
            shadow_q    <= '0;
            ftsd_ctl    <= '1;
            ftsd_in     <= '0;
            digit_idx   <= '0;
            frame_start <= 1'b0;
        end else begin
            run_q       <= run_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            ftsd_ctl    <= ctl_d;
            ftsd_in     <= in_d;
            digit_idx   <= idx_d;
            frame_start <= fs_d;
        end
    end

endmodule

// File: tb/tb_ftsd_scan_ctl_pwm.sv
// Randomized bench for ftsd_scan_ctl_pwm against a time-in-frame reference model.
module tb_ftsd_scan_ctl_pwm;

    localparam int N     = 4;
    localparam int DW    = 6;
    localparam int DWELL = 8;
    localparam int BLANK = 2;
    localparam int CW    = 4;
    localparam int FRAME = N * DWELL;

    logic          clk = 1'b0;
    logic          rst;
    logic          scan_en;
    logic [N*DW-1:0] in_bus;
    logic [N-1:0]  digit_en;
    logic [CW-1:0] brightness;
    logic [N-1:0]  ftsd_ctl;
    logic [DW-1:0] ftsd_in;
    logic [1:0]    digit_idx;
    logic          frame_start;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: scanning flag, cycle offset within the frame, latched frame codes.
    bit            m_run;
    int            m_t;
    logic [N*DW-1:0] m_shadow;

    ftsd_scan_ctl_pwm #(
        .NUM_DIGIT(N),
        .DATA_W   (DW),
        .DWELL    (DWELL),
        .BLANK    (BLANK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .scan_en    (scan_en),
        .in_bus     (in_bus),
        .digit_en   (digit_en),
        .brightness (brightness),
        .ftsd_ctl   (ftsd_ctl),
        .ftsd_in    (ftsd_in),
        .digit_idx  (digit_idx),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run    = 1'b0;
        m_t      = 0;
        m_shadow = '0;
    endtask

    task automatic compare();
        int         d, c, lim;
        bit         lit;
        logic [3:0] one_hot;
        logic [3:0] e_ctl;
        logic [N*DW-1:0] e_in;
        if (!m_run) begin
            check("ctl_idle", 32'(ftsd_ctl), 32'hf);
            check("in_idle", 32'(ftsd_in), 32'h0);
            check("idx_idle", 32'(digit_idx), 32'h0);
            check("fs_idle", 32'(frame_start), 32'h0);
        end else begin
            d   = m_t / DWELL;
            c   = m_t % DWELL;
            lim = (int'(brightness) < DWELL - BLANK) ? int'(brightness) : DWELL - BLANK;
            lit = (c >= BLANK) && ((c - BLANK) < lim) && digit_en[d];
            one_hot = 4'b1000 >> d;
            e_ctl   = lit ? ~one_hot : 4'hf;
            e_in    = (m_shadow >> (DW * d)) & 24'h3f;
            check("ctl", 32'(ftsd_ctl), 32'(e_ctl));
            check("in", 32'(ftsd_in), 32'(e_in));
            check("idx", 32'(digit_idx), 32'(d));
            check("fs", 32'(frame_start), (m_t == 0) ? 32'h1 : 32'h0);
        end
    endtask

    // One clock: inputs are stable at the edge, outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        if (!scan_en) begin
            m_run    = 1'b0;
            m_t      = 0;
            m_shadow = in_bus;
        end else if (!m_run) begin
            m_run    = 1'b1;
            m_t      = 0;
            m_shadow = in_bus;
        end else begin
            m_t = (m_t + 1) % FRAME;
            if (m_t == 0) m_shadow = in_bus;
        end
        @(negedge clk);
        compare();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_until(input int t, input string tag);
        int budget = 200;
        while (!(m_run && m_t == t) && budget > 0) begin
            step();
            budget--;
        end
        check(tag, (budget > 0) ? 32'h1 : 32'h0, 32'h1);
    endtask

    initial begin
        rst        = 1'b1;
        scan_en    = 1'b0;
        in_bus     = {6'd3, 6'd2, 6'd1, 6'd0};
        digit_en   = 4'b1111;
        brightness = 4'd6;
        model_reset();
        #12;
        check("rst_ctl", 32'(ftsd_ctl), 32'hf);
        check("rst_in", 32'(ftsd_in), 32'h0);
        check("rst_idx", 32'(digit_idx), 32'h0);
        check("rst_fs", 32'(frame_start), 32'h0);
        @(negedge clk);
        rst     = 1'b0;
        scan_en = 1'b1;
        steps(2 * FRAME + 3);

        brightness = 4'd3;
        steps(FRAME);
        brightness = 4'd0;
        steps(FRAME + 2);
        brightness = 4'd15;
        steps(FRAME);

        brightness = 4'd6;
        digit_en   = 4'b0101;
        steps(FRAME);
        digit_en   = 4'b1111;

        // Mid-frame code change must wait for the next frame.
        run_until(3, "wait_slot0");
        in_bus[11:6] = 6'd9;
        steps(2 * FRAME);

        // Drop scanning mid-slot, then re-raise with fresh codes.
        run_until(2 * DWELL + 5, "wait_drop");
        scan_en = 1'b0;
        steps(3);
        in_bus = {6'd7, 6'd6, 6'd5, 6'd4};
        steps(2);
        scan_en = 1'b1;
        steps(FRAME + 4);

        // Asynchronous reset during a lit phase, away from any clock edge.
        run_until(DWELL + 4, "wait_lit");
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("arst_ctl", 32'(ftsd_ctl), 32'hf);
        check("arst_in", 32'(ftsd_in), 32'h0);
        check("arst_idx", 32'(digit_idx), 32'h0);
        #1;
        rst = 1'b0;
        steps(FRAME + 2);

        for (int i = 0; i < 1500; i++) begin
            if (scan_en ? ($urandom_range(0, 60) == 0) : ($urandom_range(0, 3) == 0))
                scan_en = ~scan_en;
            if ($urandom_range(0, 15) == 0) brightness = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 20) == 0) digit_en = 4'($urandom);
            if ($urandom_range(0, 10) == 0) in_bus = 24'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
